// File: rtl/mc_ctl_if.sv
// -----------------------------------------------------------------------------
// mc_ctl_if -- bundle between the multicycle controller and its datapath.
//
// Signals
//   opCode, funct     instruction fields from the instruction register
//   zero              ALU zero flag (the datapath ANDs it with pc_write_cond)
//   mem_ready         memory access completes this cycle
//   pc_write .. alu_src_a   single-bit datapath strobes / selects
//   alu_src_b         0 reg B, 1 constant 4, 2 sign-ext imm, 3 imm<<2
//   pc_source         0 ALU result, 1 ALUOut, 2 jump target
//   alu_op            ALU operation code (5-bit codes zero-extended)
//   excp              sticky illegal-instruction flag
//   state             current controller state encoding
//
// Modports
//   master  controller side (mc_ctl)
//   slave   datapath side
// -----------------------------------------------------------------------------
interface mc_ctl_if #(
    parameter int ALUOP_W = 5
);
    logic [5:0]         opCode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;

    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               excp;
    logic [3:0]         state;

    modport master (
        input  opCode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, alu_op, excp, state
    );

    modport slave (
        output opCode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, ir_write, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               pc_source, alu_op, excp, state
    );
endinterface

// File: rtl/mc_ctl.sv
// -----------------------------------------------------------------------------
// mc_ctl -- Moore-style control FSM for a multicycle MIPS-subset datapath.
//
// Supports lw, sw, R-type (sll srl sra add sub and or xor nor slt),
// addi/andi/ori/xori, beq and j. Anything else raises a sticky exception
// flag and returns to FETCH.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces FETCH, clears excp and
//          holds every strobe low while asserted
//   bus    mc_ctl_if.master: instruction fields and memory handshake in,
//          datapath strobes/selects, alu_op, excp and state out
//
// Parameters
//   ALUOP_W      alu_op width (>= 5); 5-bit codes are zero-extended
//   MEM_WAIT_EN  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready
//                is ignored and every access completes in one cycle
// -----------------------------------------------------------------------------
module mc_ctl #(
    parameter int ALUOP_W     = 5,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    mc_ctl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_EXCP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b11000;
    localparam logic [4:0] ALU_OR  = 5'b11110;
    localparam logic [4:0] ALU_XOR = 5'b10110;
    localparam logic [4:0] ALU_NOR = 5'b10001;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_SLL = 5'b01000;
    localparam logic [4:0] ALU_SRL = 5'b01001;
    localparam logic [4:0] ALU_SRA = 5'b01011;

    state_t state_q, state_d;
    logic   excp_q,  excp_d;
    logic   mem_rdy;
    logic   zero_unused;

    // The controller itself never looks at zero: the datapath gates the
    // branch PC write with it.
    assign zero_unused = bus.zero;

    assign mem_rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    // -------------------------------------------------------------------------
    // Instruction field decode helpers
    // -------------------------------------------------------------------------
    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            6'b000000, 6'b000010, 6'b000011,
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b100110, 6'b100111,
            6'b101010: funct_legal = 1'b1;
            default:   funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic funct_is_shift(input logic [5:0] fn);
        funct_is_shift = (fn == 6'b000000) || (fn == 6'b000010) ||
                         (fn == 6'b000011);
    endfunction

    function automatic logic [4:0] funct_aluop(input logic [5:0] fn);
        case (fn)
            6'b000000: funct_aluop = ALU_SLL;
            6'b000010: funct_aluop = ALU_SRL;
            6'b000011: funct_aluop = ALU_SRA;
            6'b100010: funct_aluop = ALU_SUB;
            6'b100100: funct_aluop = ALU_AND;
            6'b100101: funct_aluop = ALU_OR;
            6'b100110: funct_aluop = ALU_XOR;
            6'b100111: funct_aluop = ALU_NOR;
            6'b101010: funct_aluop = ALU_SLT;
            default:   funct_aluop = ALU_ADD;
        endcase
    endfunction

    function automatic logic [4:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: imm_aluop = ALU_AND;
            OP_ORI:  imm_aluop = ALU_OR;
            OP_XORI: imm_aluop = ALU_XOR;
            default: imm_aluop = ALU_ADD;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            excp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            excp_q  <= excp_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        excp_d  = excp_q;
        case (state_q)
            S_FETCH: begin
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opCode)
                    OP_LW, OP_SW:                     state_d = S_MEMADR;
                    OP_RTYPE:                         state_d = funct_legal(bus.funct) ? S_EXEC : S_EXCP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXEC;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    default:                          state_d = S_EXCP;
                endcase
            end
            S_MEMADR: state_d = (bus.opCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_EXCP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        // The flag rises together with entry into EXCP so it is already
        // visible during the EXCP cycle, and then holds until reset.
        if (state_d == S_EXCP) excp_d = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.pc_source     = 2'd0;
        bus.alu_op        = ALUOP_W'(ALU_ADD);
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                // IR load and PC+4 commit only on the cycle the fetch completes.
                bus.ir_write  = mem_rdy;
                bus.pc_write  = mem_rdy;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'd3;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.reg_dst    = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                // Shifts take the shift amount through the immediate path.
                bus.alu_src_b = funct_is_shift(bus.funct) ? 2'd2 : 2'd0;
                bus.alu_op    = ALUOP_W'(funct_aluop(bus.funct));
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
            end
            S_IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = ALUOP_W'(imm_aluop(bus.opCode));
            end
            S_IWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_W'(ALU_SUB);
                bus.pc_source     = 2'd1;
                bus.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                bus.pc_source = 2'd2;
                bus.pc_write  = 1'b1;
            end
            default: begin
            end
        endcase
        // The state register is already FETCH during reset, but FETCH would
        // still drive mem_read; hold every strobe low until reset drops.
        if (reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_op        = '0;
        end
    end

    assign bus.state = state_q;
    assign bus.excp  = excp_q;

endmodule

// File: tb/tb_mc_ctl.sv
module tb_mc_ctl;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC   = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_IEXEC  = 4'd8;
    localparam logic [3:0] ST_IWB    = 4'd9;
    localparam logic [3:0] ST_BRANCH = 4'd10;
    localparam logic [3:0] ST_JUMP   = 4'd11;
    localparam logic [3:0] ST_EXCP   = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // Strobe bit positions inside the expected-record vector.
    localparam int B_PCW  = 9;
    localparam int B_PCWC = 8;
    localparam int B_IORD = 7;
    localparam int B_IRW  = 6;
    localparam int B_MRD  = 5;
    localparam int B_MWR  = 4;
    localparam int B_M2R  = 3;
    localparam int B_RDST = 2;
    localparam int B_RW   = 1;
    localparam int B_SRCA = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [9:0] strb;
        logic [1:0] srcb;
        logic [1:0] pcs;
        logic [4:0] aluop;
        logic       ex;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opc, fn;
    logic       zr, mr;
    logic [5:0] nxt_op, nxt_fn;
    logic       excp_m;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    mc_ctl_if #(.ALUOP_W(5)) bus5 ();
    mc_ctl_if #(.ALUOP_W(8)) bus8 ();

    assign bus5.opCode = opc;  assign bus8.opCode = opc;
    assign bus5.funct = fn;    assign bus8.funct = fn;
    assign bus5.zero = zr;     assign bus8.zero = zr;
    assign bus5.mem_ready = mr; assign bus8.mem_ready = mr;

    mc_ctl #(.ALUOP_W(5), .MEM_WAIT_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus5));
    mc_ctl #(.ALUOP_W(8), .MEM_WAIT_EN(1'b1)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, want);
        end
    endtask

    // ---------------- reference model: outputs by state, from the rule table
    function automatic logic funct_ok(input logic [5:0] f);
        return f inside {6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100010,
                         6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    endfunction

    function automatic logic [4:0] r_code(input logic [5:0] f);
        case (f)
            6'b000000: return 5'b01000;
            6'b000010: return 5'b01001;
            6'b000011: return 5'b01011;
            6'b100010: return 5'b00001;
            6'b100100: return 5'b11000;
            6'b100101: return 5'b11110;
            6'b100110: return 5'b10110;
            6'b100111: return 5'b10001;
            6'b101010: return 5'b00111;
            default:   return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] i_code(input logic [5:0] op);
        case (op)
            OP_ANDI: return 5'b11000;
            OP_ORI:  return 5'b11110;
            OP_XORI: return 5'b10110;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic exp_t exp_for(input logic [3:0] st, input logic [5:0] op,
                                     input logic [5:0] f, input logic r, input logic ex);
        exp_t e;
        e = '0;
        e.st = st;
        e.ex = ex;
        case (st)
            ST_FETCH:  begin e.strb[B_MRD] = 1; e.srcb = 2'd1; e.strb[B_IRW] = r; e.strb[B_PCW] = r; end
            ST_DECODE: e.srcb = 2'd3;
            ST_MEMADR: begin e.strb[B_SRCA] = 1; e.srcb = 2'd2; end
            ST_MEMRD:  begin e.strb[B_MRD] = 1; e.strb[B_IORD] = 1; end
            ST_MEMWB:  begin e.strb[B_RW] = 1; e.strb[B_M2R] = 1; e.strb[B_RDST] = 1; end
            ST_MEMWR:  begin e.strb[B_MWR] = 1; e.strb[B_IORD] = 1; end
            ST_EXEC: begin
                e.strb[B_SRCA] = 1;
                e.srcb  = (f == 6'b000000 || f == 6'b000010 || f == 6'b000011) ? 2'd2 : 2'd0;
                e.aluop = r_code(f);
            end
            ST_RWB:    e.strb[B_RW] = 1;
            ST_IEXEC:  begin e.strb[B_SRCA] = 1; e.srcb = 2'd2; e.aluop = i_code(op); end
            ST_IWB:    begin e.strb[B_RW] = 1; e.strb[B_RDST] = 1; end
            ST_BRANCH: begin e.strb[B_SRCA] = 1; e.aluop = 5'b00001; e.pcs = 2'd1; e.strb[B_PCWC] = 1; end
            ST_JUMP:   begin e.pcs = 2'd2; e.strb[B_PCW] = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // ---------------- stimulus: one call per clock cycle, pushes its expectation
    task automatic step(input logic [3:0] st, input logic r);
        @(posedge clk);
        #1;
        opc = nxt_op;
        fn  = nxt_fn;
        mr  = r;
        zr  = 1'($urandom);
        if (st == ST_EXCP) excp_m = 1'b1;
        sb.push_back(exp_for(st, opc, fn, r, excp_m));
    endtask

    task automatic mem_phase(input logic [3:0] st, input int stalls);
        for (int i = 0; i < stalls; i++) step(st, 1'b0);
        step(st, 1'b1);
    endtask

    // Walks one instruction through its cycle sequence as the ISA defines it.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input int fstall, input int mstall);
        nxt_op = op;
        nxt_fn = f;
        mem_phase(ST_FETCH, fstall);
        step(ST_DECODE, 1'($urandom));
        if (op == OP_LW) begin
            step(ST_MEMADR, 1'($urandom));
            mem_phase(ST_MEMRD, mstall);
            step(ST_MEMWB, 1'($urandom));
        end else if (op == OP_SW) begin
            step(ST_MEMADR, 1'($urandom));
            mem_phase(ST_MEMWR, mstall);
        end else if (op == OP_R && funct_ok(f)) begin
            step(ST_EXEC, 1'($urandom));
            step(ST_RWB, 1'($urandom));
        end else if (op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI}) begin
            step(ST_IEXEC, 1'($urandom));
            step(ST_IWB, 1'($urandom));
        end else if (op == OP_BEQ) begin
            step(ST_BRANCH, 1'($urandom));
        end else if (op == OP_J) begin
            step(ST_JUMP, 1'($urandom));
        end else begin
            step(ST_EXCP, 1'($urandom));
        end
    endtask

    function automatic logic [5:0] rst_strobes();
        return {bus5.pc_write, bus5.ir_write, bus5.mem_read,
                bus5.mem_write, bus5.reg_write, bus5.pc_write_cond};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus5.state), 32'd0);
        check({tag, "_excp"},  32'(bus5.excp), 32'd0);
        check({tag, "_strobes"}, 32'(rst_strobes()), 32'd0);
        check({tag, "_alu_op"}, 32'(bus5.alu_op), 32'd0);
        check({tag, "_alu_op8"}, 32'(bus8.alu_op), 32'd0);
    endtask

    // ---------------- monitor: one expectation consumed per presented cycle
    initial begin
        exp_t e;
        logic [9:0] got_strb;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got_strb = {bus5.pc_write, bus5.pc_write_cond, bus5.iord, bus5.ir_write,
                            bus5.mem_read, bus5.mem_write, bus5.mem_to_reg, bus5.reg_dst,
                            bus5.reg_write, bus5.alu_src_a};
                check("state", 32'(bus5.state), 32'(e.st));
                check("strobes", 32'(got_strb), 32'(e.strb));
                check("alu_src_b", 32'(bus5.alu_src_b), 32'(e.srcb));
                check("pc_source", 32'(bus5.pc_source), 32'(e.pcs));
                check("alu_op", 32'(bus5.alu_op), 32'(e.aluop));
                check("excp", 32'(bus5.excp), 32'(e.ex));
                check("alu_op_w8", 32'(bus8.alu_op), {27'd0, e.aluop});
                check("state_w8", 32'(bus8.state), 32'(e.st));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence
    initial begin
        logic [5:0] legal_f [10] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100010,
                                     6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
        logic [5:0] imm_op [4] = '{OP_ADDI, OP_ANDI, OP_ORI, OP_XORI};
        logic [5:0] op, f;
        int k;

        reset = 1'b1; mr = 1'b1; zr = 1'b0; opc = OP_LW; fn = 6'd0;
        nxt_op = OP_LW; nxt_fn = 6'd0; excp_m = 1'b0;
        #2;
        check_reset_outputs("reset_init");
        @(posedge clk); #1;
        mr = 1'b0;
        reset = 1'b0;

        run_instr(OP_LW, 6'd0, 0, 0);              // plain lw
        run_instr(OP_R, 6'b100000, 0, 0);          // add
        run_instr(OP_R, 6'b000011, 1, 0);          // sra
        run_instr(OP_SW, 6'd0, 0, 3);              // sw with three stall cycles
        run_instr(6'b111111, 6'd0, 0, 0);          // illegal opcode
        run_instr(OP_ADDI, 6'd0, 0, 0);            // excp must stay set
        run_instr(OP_BEQ, 6'd0, 0, 0);
        run_instr(OP_BEQ, 6'd0, 2, 0);
        run_instr(OP_ORI, 6'd0, 0, 0);             // 0x1E on the 8-bit build
        run_instr(OP_R, 6'b001000, 0, 0);          // illegal funct
        run_instr(OP_J, 6'd0, 0, 0);
        run_instr(OP_LW, 6'd0, 1, 2);

        // Reset pulse in the middle of a stalled load.
        nxt_op = OP_LW; nxt_fn = 6'd0;
        mem_phase(ST_FETCH, 0);
        step(ST_DECODE, 1'b1);
        step(ST_MEMADR, 1'b1);
        step(ST_MEMRD, 1'b0);
        #5;
        reset = 1'b1;
        mr = 1'b1;
        #1;
        check_reset_outputs("reset_memrd");
        excp_m = 1'b0;
        @(posedge clk); #1;
        mr = 1'b0;
        reset = 1'b0;
        run_instr(OP_SW, 6'd0, 1, 1);

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 9);
            f = legal_f[$urandom_range(0, 9)];
            case (k)
                0: op = OP_LW;
                1: op = OP_SW;
                2, 3, 9: op = OP_R;
                4: begin op = OP_R; f = 6'($urandom); end
                5: op = imm_op[$urandom_range(0, 3)];
                6: op = OP_BEQ;
                7: op = OP_J;
                default: op = 6'($urandom);
            endcase
            run_instr(op, f, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(negedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
